// File: rtl/croc_boot_seq.sv
// croc_boot_seq: board-level boot sequencer for the Croc FPGA top.
// Holds the SoC in reset until the clock wizard lock has been stable for
// LockStableCycles, keeps reset asserted for RstHoldCycles more, then waits
// for a debounced button press before raising fetch_en. Losing lock at any
// point drops the SoC straight back into reset.
// Optional feature: define CROC_BOOT_AUTOFETCH_EN to raise fetch_en
// automatically FetchDelayCycles after reset release instead of on a press.
module croc_boot_seq #(
  parameter int LockStableCycles = 1024,
  parameter int RstHoldCycles    = 64,
  parameter int DebounceCycles   = 100000,
  parameter int FetchDelayCycles = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pll_locked_i,
  input  logic       fetch_btn_i,
  output logic       soc_rst_no,
  output logic       fetch_en_o,
  output logic [2:0] state_o
);

  // Counter widths: just wide enough to hold the terminal count, never zero.
  localparam int LockW = (LockStableCycles > 1) ? $clog2(LockStableCycles) : 1;
  localparam int HoldW = (RstHoldCycles > 1) ? $clog2(RstHoldCycles) : 1;
  localparam int DebW  = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;

  localparam logic [LockW-1:0] LockLast = LockW'(LockStableCycles - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RstHoldCycles - 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DebounceCycles - 1);

  // Every cycle count must be at least one, otherwise the terminal counts wrap.
  if (LockStableCycles < 1) begin : gen_bad_lock
    $error("croc_boot_seq: LockStableCycles must be >= 1");
  end
  if (RstHoldCycles < 1) begin : gen_bad_hold
    $error("croc_boot_seq: RstHoldCycles must be >= 1");
  end
  if (DebounceCycles < 1) begin : gen_bad_deb
    $error("croc_boot_seq: DebounceCycles must be >= 1");
  end
  if (FetchDelayCycles < 1) begin : gen_bad_fetch
    $error("croc_boot_seq: FetchDelayCycles must be >= 1");
  end

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    HOLD_RST   = 3'd1,
    WAIT_FETCH = 3'd2,
    RUN        = 3'd3
  } state_e;

  logic lock_q1, lock_s;
  logic btn_q1, btn_s;

  logic            btn_d;
  logic [DebW-1:0] deb_cnt;
  logic            press;

  state_e           state_q, state_d;
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

  // Two-flop synchronizers for the asynchronous lock flag and raw button.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q1 <= 1'b0;
      lock_s  <= 1'b0;
      btn_q1  <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      lock_q1 <= pll_locked_i;
      lock_s  <= lock_q1;
      btn_q1  <= fetch_btn_i;
      btn_s   <= btn_q1;
    end
  end

  // Debouncer: accept a new button level only after it has differed from the
  // current debounced level for DebounceCycles consecutive cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_d   <= 1'b0;
      deb_cnt <= '0;
    end else if (btn_s == btn_d) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DebLast) begin
      btn_d   <= ~btn_d;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + DebW'(1);
    end
  end

`ifdef CROC_BOOT_AUTOFETCH_EN
  localparam int DelayW = (FetchDelayCycles > 1) ? $clog2(FetchDelayCycles) : 1;
  localparam logic [DelayW-1:0] DelayLast = DelayW'(FetchDelayCycles - 1);

  logic [DelayW-1:0] delay_cnt_q, delay_cnt_d;

  // The button is not needed to leave WAIT_FETCH in this build.
  assign press = 1'b0;

  // Delay counter register for the automatic fetch release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      delay_cnt_q <= '0;
    end else begin
      delay_cnt_q <= delay_cnt_d;
    end
  end
`else
  logic btn_d_q;

  // Delayed debounced level, used to turn the rising edge into a one-cycle press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_d_q <= 1'b0;
    end else begin
      btn_d_q <= btn_d;
    end
  end

  assign press = btn_d & ~btn_d_q;
`endif

  // State and phase counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= WAIT_LOCK;
      lock_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Next state: lock loss wins over everything; counters run only in their own phase.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = '0;
    hold_cnt_d = '0;
`ifdef CROC_BOOT_AUTOFETCH_EN
    delay_cnt_d = '0;
`endif
    if (state_q != WAIT_LOCK && !lock_s) begin
      state_d = WAIT_LOCK;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            if (lock_cnt_q == LockLast) begin
              state_d = HOLD_RST;
            end else begin
              lock_cnt_d = lock_cnt_q + LockW'(1);
            end
          end
        end
        HOLD_RST: begin
          if (hold_cnt_q == HoldLast) begin
            state_d = WAIT_FETCH;
          end else begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
        end
        WAIT_FETCH: begin
`ifdef CROC_BOOT_AUTOFETCH_EN
          if (delay_cnt_q == DelayLast) begin
            state_d = RUN;
          end else begin
            delay_cnt_d = delay_cnt_q + DelayW'(1);
          end
`else
          if (press) begin
            state_d = RUN;
          end
`endif
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = WAIT_LOCK;
        end
      endcase
    end
  end

  // Registered output decode of the current state, one cycle behind it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      soc_rst_no <= 1'b0;
      fetch_en_o <= 1'b0;
    end else begin
      soc_rst_no <= (state_q == WAIT_FETCH) || (state_q == RUN);
      fetch_en_o <= (state_q == RUN);
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_croc_boot_seq.sv
// tb_croc_boot_seq: directed bench for croc_boot_seq with a timeline-based
// reference model checked every cycle, plus hand-computed latency checks.
// Honours CROC_BOOT_AUTOFETCH_EN the same way the design does.
module tb_croc_boot_seq;

  localparam int LOCK = 8;
  localparam int HOLD = 4;
  localparam int DEB  = 5;
  localparam int FDLY = 3;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       pll_locked_i = 1'b0;
  logic       fetch_btn_i = 1'b0;
  logic       soc_rst_no;
  logic       fetch_en_o;
  logic [2:0] state_o;

  int total = 0;
  int bad = 0;
  bit checking = 1'b1;

  croc_boot_seq #(
    .LockStableCycles(LOCK),
    .RstHoldCycles(HOLD),
    .DebounceCycles(DEB),
    .FetchDelayCycles(FDLY)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .pll_locked_i(pll_locked_i),
    .fetch_btn_i(fetch_btn_i),
    .soc_rst_no(soc_rst_no),
    .fetch_en_o(fetch_en_o),
    .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state: input histories, how long lock has been seen high,
  // and whether an accepted press has been taken in WAIT_FETCH.
  int         run_len = 0;
  bit         deb_level = 1'b0;
  bit         rose_last = 1'b0;
  bit         fetched = 1'b0;
  bit         pll_hist[$];
  bit         btn_hist[$];
  logic [2:0] exp_state = 3'd0;
  logic       exp_rst_n = 1'b0;
  logic       exp_fetch = 1'b0;

  function automatic bit hist_at(input bit q[$], input int i);
    return (i < q.size()) ? q[i] : 1'b0;
  endfunction

  // Model: the boot phase is a function of how many consecutive edges the
  // synchronized lock has been high; the button is accepted once its synced
  // level has disagreed with the debounced level over a full window.
  always @(posedge clk_i or negedge rst_ni) begin : model
    bit lock_seen;
    bit press;
    bit all_differ;
    int prev_state;
    if (!rst_ni) begin
      pll_hist.delete();
      btn_hist.delete();
      run_len   = 0;
      deb_level = 1'b0;
      rose_last = 1'b0;
      fetched   = 1'b0;
      exp_state = 3'd0;
      exp_rst_n = 1'b0;
      exp_fetch = 1'b0;
    end else begin
      pll_hist.push_front(pll_locked_i);
      btn_hist.push_front(fetch_btn_i);
      while (pll_hist.size() > 3) void'(pll_hist.pop_back());
      while (btn_hist.size() > DEB + 2) void'(btn_hist.pop_back());
      lock_seen = hist_at(pll_hist, 2);

      press = rose_last;
      rose_last = 1'b0;
      all_differ = 1'b1;
      for (int i = 2; i < DEB + 2; i++) begin
        if (hist_at(btn_hist, i) == deb_level) all_differ = 1'b0;
      end
      if (all_differ) begin
        deb_level = ~deb_level;
        rose_last = deb_level;
      end

      prev_state = int'(exp_state);
      exp_rst_n = (prev_state == 2) || (prev_state == 3);
      exp_fetch = (prev_state == 3);

      if (!lock_seen) begin
        run_len   = 0;
        fetched   = 1'b0;
        exp_state = 3'd0;
      end else begin
        run_len++;
        if (run_len < LOCK) exp_state = 3'd0;
        else if (run_len < LOCK + HOLD) exp_state = 3'd1;
        else begin
`ifdef CROC_BOOT_AUTOFETCH_EN
          exp_state = (run_len >= LOCK + HOLD + FDLY) ? 3'd3 : 3'd2;
`else
          if (prev_state == 2 && press) fetched = 1'b1;
          exp_state = fetched ? 3'd3 : 3'd2;
`endif
        end
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk_i) begin
    if (checking) begin
      total++;
      if (state_o !== exp_state || soc_rst_no !== exp_rst_n || fetch_en_o !== exp_fetch) begin
        bad++;
        $display("[TB] FAIL model_cmp t=%0t: dut state=%0d rst_n=%b fetch=%b, model state=%0d rst_n=%b fetch=%b",
                 $time, state_o, soc_rst_no, fetch_en_o, exp_state, exp_rst_n, exp_fetch);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check_output(input string name, input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  // Count rising edges until an observable event; sel 0 = state_o==val,
  // 1 = soc_rst_no high, 2 = fetch_en_o high, 3 = both outputs low.
  task automatic cycles_until(input int sel, input int val, input string name, output int n);
    bit hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < 200) begin
      @(posedge clk_i);
      #1;
      n++;
      case (sel)
        0:       hit = (state_o === 3'(val));
        1:       hit = (soc_rst_no === 1'b1);
        2:       hit = (fetch_en_o === 1'b1);
        default: hit = (soc_rst_no === 1'b0) && (fetch_en_o === 1'b0);
      endcase
    end
    if (!hit) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: event not seen within 200 cycles", name);
      n = -1;
    end
  endtask

  // Full relock from pll rising: HOLD_RST after LOCK+2 edges, reset release 5 later.
  task automatic relock_and_release(input string tag);
    int n;
    pll_locked_i = 1'b1;
    cycles_until(0, 1, {tag, "_hold_entry"}, n);
    check_output({tag, "_hold_entry"}, n, 10);
    cycles_until(1, 0, {tag, "_rst_release"}, n);
    check_output({tag, "_rst_release"}, n, 5);
    check_output({tag, "_state_wait_fetch"}, int'(state_o), 2);
  endtask

  // Get from WAIT_FETCH (just after release) to RUN, by button or by timer.
  task automatic reach_run(input string tag);
    int n;
`ifdef CROC_BOOT_AUTOFETCH_EN
    cycles_until(2, 0, {tag, "_autofetch"}, n);
    check_output({tag, "_autofetch"}, n, FDLY);
`else
    tick(10);
    check_output({tag, "_no_stale_press"}, int'(state_o), 2);
    fetch_btn_i = 1'b1;
    cycles_until(2, 0, {tag, "_press_fetch"}, n);
    check_output({tag, "_press_fetch"}, n, DEB + 4);
`endif
    check_output({tag, "_state_run"}, int'(state_o), 3);
  endtask

  initial begin : apply_stimulus
    int n;
    #23 rst_ni = 1'b1;

    // Idle with no lock: everything must stay in reset.
    tick(50);
    check_output("idle_state", int'(state_o), 0);
    check_output("idle_rst_n", int'(soc_rst_no), 0);
    check_output("idle_fetch", int'(fetch_en_o), 0);

    // Lock glitch: 5 high, 1 low, then steady; counting restarts at the glitch.
    pll_locked_i = 1'b1;
    tick(5);
    pll_locked_i = 1'b0;
    tick(1);
    relock_and_release("glitch");

    // Bouncy button: 2-cycle toggles never satisfy the debounce window.
`ifdef CROC_BOOT_AUTOFETCH_EN
    cycles_until(2, 0, "auto_fetch_first", n);
    check_output("auto_fetch_first", n, FDLY);
`endif
    for (int i = 0; i < 5; i++) begin
      fetch_btn_i = 1'b1;
      tick(2);
      fetch_btn_i = 1'b0;
      tick(2);
    end
`ifdef CROC_BOOT_AUTOFETCH_EN
    check_output("bounce_state", int'(state_o), 3);
`else
    check_output("bounce_no_press", int'(state_o), 2);
    fetch_btn_i = 1'b1;
    cycles_until(2, 0, "bounce_steady_fetch", n);
    check_output("bounce_steady_fetch", n, DEB + 4);
    check_output("bounce_state_run", int'(state_o), 3);
`endif

    // Lock loss in RUN: both outputs low exactly 4 edges later.
    tick(5);
    fetch_btn_i = 1'b0;
    tick(12);
    pll_locked_i = 1'b0;
    cycles_until(3, 0, "lockloss_outputs", n);
    check_output("lockloss_outputs", n, 4);
    check_output("lockloss_state", int'(state_o), 0);

    // A press while waiting for lock must be dropped, not remembered.
    fetch_btn_i = 1'b1;
    tick(12);
    fetch_btn_i = 1'b0;
    tick(12);
    relock_and_release("relock");
    reach_run("relock");

    // Async reset in the middle of HOLD_RST.
    fetch_btn_i = 1'b0;
    tick(12);
    pll_locked_i = 1'b0;
    cycles_until(3, 0, "lockloss2_outputs", n);
    check_output("lockloss2_outputs", n, 4);
    pll_locked_i = 1'b1;
    cycles_until(0, 1, "pre_reset_hold", n);
    check_output("pre_reset_hold", n, 10);
    tick(2);
    #1 rst_ni = 1'b0;
    #1;
    check_output("async_rst_state", int'(state_o), 0);
    check_output("async_rst_rst_n", int'(soc_rst_no), 0);
    check_output("async_rst_fetch", int'(fetch_en_o), 0);
    #4 rst_ni = 1'b1;
    cycles_until(0, 1, "post_reset_hold", n);
    check_output("post_reset_hold", n, 10);
    cycles_until(1, 0, "post_reset_release", n);
    check_output("post_reset_release", n, 5);
    reach_run("post_reset");

    // Async reset while running: outputs drop without waiting for a clock.
    tick(3);
    #1 rst_ni = 1'b0;
    #1;
    check_output("run_rst_state", int'(state_o), 0);
    check_output("run_rst_rst_n", int'(soc_rst_no), 0);
    check_output("run_rst_fetch", int'(fetch_en_o), 0);
    #3 rst_ni = 1'b1;
    tick(20);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
